// File: rtl/btb_pkg.sv
// btb_pkg: shared state encoding and PC/counter helpers for the BTB
package btb_pkg;
  typedef enum logic {RUN, FLUSH} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int entries);
    return (pc >> 2) & ((64'd1 << clog2(entries)) - 64'd1);
  endfunction
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int entries, input int addr_w);
    return (pc >> (clog2(entries) + 2)) & ((64'd1 << (addr_w - clog2(entries) - 2)) - 64'd1);
  endfunction
  function automatic logic [31:0] ctr_inc(input logic [31:0] c, input int w);
    return (c == (32'd1 << w) - 32'd1) ? c : c + 32'd1;
  endfunction
  function automatic logic [31:0] ctr_dec(input logic [31:0] c);
    return (c == 32'd0) ? c : c - 32'd1;
  endfunction
endpackage

// File: rtl/btb_sat_ctr.sv
// btb_sat_ctr: combinational saturating up/down direction counter
module btb_sat_ctr
  import btb_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  input  logic             en,
  output logic [CTR_W-1:0] ctr_nx
);
  always_comb ctr_nx = !en ? ctr : inc ? CTR_W'(ctr_inc(32'(ctr), CTR_W)) : CTR_W'(ctr_dec(32'(ctr)));
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: direct-mapped BTB with zero-latency lookup, counter updates and flush sweep
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int ADDR_W   = 32,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush,
  output logic              ready,
  output logic              upd_we
);
  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  state_t               state, state_nx;
  logic [IDX_W-1:0]     fl_idx;
  logic [ENTRIES-1:0]   valid;
  logic [TAG_W-1:0]     tag_q [ENTRIES];
  logic [ADDR_W-1:0]    tgt_q [ENTRIES];
  logic [CTR_W-1:0]     ctr_q [ENTRIES];
  logic [IDX_W-1:0]     l_idx, u_idx;
  logic [TAG_W-1:0]     l_tag, u_tag;
  logic                 u_hit;
  logic [CTR_W-1:0]     ctr_sat, ctr_wr;
  always_comb begin
    l_idx       = IDX_W'(pc_index(64'(lookup_pc), ENTRIES));
    l_tag       = TAG_W'(pc_tag(64'(lookup_pc), ENTRIES, ADDR_W));
    u_idx       = IDX_W'(pc_index(64'(upd_pc), ENTRIES));
    u_tag       = TAG_W'(pc_tag(64'(upd_pc), ENTRIES, ADDR_W));
    pred_hit    = (state == RUN) && valid[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && ctr_q[l_idx][CTR_W-1];
    pred_target = pred_hit ? tgt_q[l_idx] : '0;
    u_hit       = valid[u_idx] && (tag_q[u_idx] == u_tag);
    upd_we      = (state == RUN) && upd_valid && !flush && (u_hit || upd_taken);
    ctr_wr      = u_hit ? ctr_sat : CTR_W'(INIT_CTR);
    ready       = (state == RUN);
    state_nx    = (state == RUN) ? (flush ? FLUSH : RUN)
                                 : (fl_idx == IDX_W'(ENTRIES - 1) ? RUN : FLUSH);
  end
  btb_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
    .ctr    (ctr_q[u_idx]),
    .inc    (upd_taken),
    .en     (u_hit),
    .ctr_nx (ctr_sat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      fl_idx <= '0;
      valid  <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_W'(INIT_CTR);
    end else begin
      state  <= state_nx;
      fl_idx <= (state == FLUSH) ? fl_idx + IDX_W'(1) : '0;
      if (state == FLUSH) valid[fl_idx] <= 1'b0;
      if (upd_we) begin
        valid[u_idx] <= 1'b1;
        ctr_q[u_idx] <= ctr_wr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_q[u_idx] <= u_tag;
      if (upd_taken) tgt_q[u_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc, upd_pc, upd_target, pred_target;
  logic        pred_hit, pred_taken, upd_valid, upd_taken, flush, ready, upd_we;
  int          checks = 0;
  int          errors = 0;
  btb_update_ctrl #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2), .INIT_CTR(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush),
    .ready       (ready),
    .upd_we      (upd_we)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic exp_we);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tgt;
    #1;
    chk("upd_we", upd_we, exp_we);
    tick();
    upd_valid = 1'b0;
  endtask
  task automatic look(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk("pred_hit", pred_hit, hit);
    chk("pred_taken", pred_taken, tk);
    chk("pred_target", pred_target, tgt);
  endtask
  task automatic all_miss();
    for (int i = 0; i < 16; i++) begin
      look(32'h0040_0000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
      look(32'h0080_0000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
    end
  endtask
  task automatic fill();
    upd(32'h0040_0000, 1'b1, 32'h0000_0111, 1'b1);
    upd(32'h0080_0010, 1'b1, 32'h0000_0444, 1'b1);
    upd(32'h0040_003C, 1'b1, 32'h0000_0FFF, 1'b1);
    look(32'h0040_003C, 1'b1, 1'b1, 32'h0000_0FFF);
  endtask
  initial begin
    rst_n = 1'b0;
    lookup_pc = 32'h0040_0010;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    flush = 1'b0;
    tick();
    look(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_upd_we", upd_we, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    look(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    chk("ready_run", ready, 1'b1);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1);
    look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    for (int i = 0; i < 3; i++) begin
      upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1);
      look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    end
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1);
    look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    for (int i = 0; i < 3; i++) begin
      upd(32'h0040_0010, 1'b0, 32'h0, 1'b1);
      look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
    end
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1);
    look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
    upd(32'h0080_0010, 1'b1, 32'h0080_0200, 1'b1);
    look(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    look(32'h0080_0010, 1'b1, 1'b1, 32'h0080_0200);
    upd(32'h0080_0010, 1'b0, 32'h0, 1'b1);
    look(32'h0080_0010, 1'b1, 1'b0, 32'h0080_0200);
    upd(32'h0040_0020, 1'b0, 32'h0040_0999, 1'b0);
    look(32'h0040_0020, 1'b0, 1'b0, 32'h0);
    lookup_pc = 32'h0080_0010;
    upd_valid = 1'b1;
    upd_pc = 32'h0080_0010;
    upd_taken = 1'b1;
    upd_target = 32'h0080_0300;
    #1;
    chk("same_cyc_target", pred_target, 32'h0080_0200);
    chk("same_cyc_taken", pred_taken, 1'b0);
    tick();
    upd_valid = 1'b0;
    look(32'h0080_0010, 1'b1, 1'b1, 32'h0080_0300);
    fill();
    flush = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h0040_0020;
    upd_taken = 1'b1;
    upd_target = 32'h0040_0222;
    #1;
    chk("flush_upd_we", upd_we, 1'b0);
    tick();
    flush = 1'b0;
    lookup_pc = 32'h0040_003C;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("flush_ready", ready, 1'b0);
      chk("flush_drop_we", upd_we, 1'b0);
      chk("flush_pred_hit", pred_hit, 1'b0);
      tick();
    end
    upd_valid = 1'b0;
    chk("flush_done_ready", ready, 1'b1);
    all_miss();
    fill();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_ready_run", ready, 1'b1);
    all_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Parametrised branch target buffer with integrated update control for the MIPS fetch stage. It performs a zero-latency lookup on the fetch PC and returns hit, taken-prediction and target. It generates the BTB write enable from resolved-branch updates, with per-entry saturating direction counters. It also provides a multi-cycle flush sequencer that invalidates every entry.

## Interface
- ENTRIES, 16, number of direct-mapped entries; power of two, ≥ 2
- ADDR_W, 32, PC and target width
- CTR_W, 2, direction counter width
- INIT_CTR, 2, counter value written on allocation (weakly taken)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- lookup_pc  in  ADDR_W  fetch PC
- pred_hit  out  1  valid entry with matching tag at lookup index
- pred_taken  out  1  pred_hit & counter MSB
- pred_target  out  ADDR_W  stored target; 0 when pred_hit=0
- upd_valid  in  1  resolved-branch update strobe, one cycle per branch
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_taken  in  1  resolved direction
- upd_target  in  ADDR_W  resolved target
- flush  in  1  request full invalidate
- ready  out  1  1 in RUN; 0 while flushing
- upd_we  out  1  entry write occurs this cycle

## Operation
- IDX_W = log2(ENTRIES).
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Entry fields: valid, tag, target, ctr[CTR_W-1:0].
- FSM states:
  - RUN: normal operation.
  - FLUSH: sweep counter fl_idx walks 0..ENTRIES-1 and clears valid[fl_idx] on each cycle. The transition to RUN happens after the cycle that clears entry ENTRIES-1.
- RUN→FLUSH when flush=1. FLUSH ignores flush.
- Update rules, applied in RUN with upd_valid=1 and flush=0:
  - Hit and taken: ctr saturating +1 (caps at 2^CTR_W−1); target ← upd_target; upd_we=1.
  - Hit and not taken: ctr saturating −1 (floors at 0); entry stays valid; upd_we=1.
  - Miss and taken: allocate. valid=1, tag and target written, ctr=INIT_CTR; any previous occupant is overwritten. upd_we=1.
  - Miss and not taken: no write; upd_we=0.
- A hit on update means valid and tag match at the update index.
- Flush and upd_valid in the same RUN cycle: flush wins. The update is dropped and upd_we=0.
- In FLUSH: upd_valid is dropped with upd_we=0, and pred_hit/pred_taken are forced to 0. Upstream must gate updates on ready.

## Timing
- Reset (asynchronous, rst_n=0): all valid=0, all ctr=INIT_CTR, state=RUN, fl_idx=0.
- Tag and target arrays are not reset.
- Output values during and after reset: pred_hit=0, pred_taken=0, pred_target=0, ready=1, upd_we=0.
- Lookup is combinational, zero latency.
- Update is written at the rising edge that ends the upd_valid cycle.
- A lookup in the same cycle as an update to the same index returns pre-update contents; there is no bypass.
- upd_we is combinational in the update cycle.
- flush sampled at edge N: ready=0 from N+1 through N+ENTRIES, and ready=1 at N+ENTRIES+1. The flush therefore occupies exactly ENTRIES cycles.
- Reset asserted mid-flush aborts the sweep. All entries are invalid and ready=1 immediately.
- fl_idx wraps to 0 on FLUSH exit.

## Structure
- Shared package btb_pkg holds:
  - state enum {RUN, FLUSH}
  - function clog2 for IDX_W
  - index and tag extraction functions parametrised by ENTRIES/ADDR_W
  - counter saturating increment and decrement functions
- One natural sub-module: btb_sat_ctr. It is combinational, has parameter CTR_W, and takes inputs ctr, inc and en, producing the next ctr.
- The array and FSM stay in btb_update_ctrl.

## Test plan
All scenarios use ENTRIES=16.

- Reset, then lookup_pc=0x0040_0010 → pred_hit=0, pred_target=0, ready=1.
- Update pc=0x0040_0010, taken, target=0x0040_0100 → upd_we=1. The next-cycle lookup of the same PC gives pred_hit=1, pred_taken=1, target 0x0040_0100.
- Counter saturation on the same entry:
  - Three taken updates → ctr=3.
  - Then four not-taken updates → ctr=0 with no wrap, pred_taken=0, pred_hit=1.
- Alias and not-taken miss:
  - Entry holds 0x0040_0010 (index 4). Update pc=0x0080_0010, taken → replaces the entry. Lookup 0x0040_0010 misses; lookup 0x0080_0010 hits with ctr=2.
  - Not-taken update to an empty index → upd_we=0 and no state change.
- Same-cycle lookup and update of one entry → lookup shows old target/ctr; the new values are visible the following cycle.
- Flush and update together:
  - flush=1 in the same cycle as upd_valid=1 → upd_we=0.
  - ready is low for exactly 16 cycles. Updates during that window are dropped.
  - Afterwards every index misses.
  - A repeat with rst_n pulsed at flush cycle 5 gives ready=1 immediately and all entries missing.
